cpu_control: RTL and testbench



---
 rtl/cpu_pkg.sv | 15 +
 rtl/dec3to8.sv | 10 +
 rtl/cpu_control.sv | 69 ++++++
 tb/tb_cpu_control.sv | 133 +++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants, IR field positions and step encoding for the CPU control sequencer.
package cpu_pkg;
    localparam int REG_SEL_W = 3;
    localparam int OP_W      = 3;
    localparam int NREG      = 2 ** REG_SEL_W;
    localparam int IR_W      = OP_W + 2 * REG_SEL_W;
    localparam int Y_LSB     = 0;
    localparam int X_LSB     = REG_SEL_W;
    localparam int OP_LSB    = 2 * REG_SEL_W;
    localparam logic [OP_W-1:0] OP_MV  = 3'b000;
    localparam logic [OP_W-1:0] OP_MVI = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD = 3'b010;
    localparam logic [OP_W-1:0] OP_SUB = 3'b011;
    typedef enum logic [1:0] {T0, T1, T2, T3} step_t;
endpackage

// File: rtl/dec3to8.sv
// dec3to8: one-hot decoder with enable; all outputs low when disabled.
module dec3to8 #(
    parameter int W = 3
) (
    input  logic           en_i,
    input  logic [W-1:0]   sel_i,
    output logic [2**W-1:0] y_o
);
    assign y_o = en_i ? {{(2**W-1){1'b0}}, 1'b1} << sel_i : '0;
endmodule

// File: rtl/cpu_control.sv
// cpu_control: T0..T3 step counter and per-step control strobe decode for the bus-based CPU.
import cpu_pkg::*;
module cpu_control (
    input  logic            clock,
    input  logic            reset,
    input  logic            run,
    input  logic [IR_W-1:0] ir,
    output logic            irin,
    output logic [NREG-1:0] rin,
    output logic [NREG-1:0] rout,
    output logic            ain,
    output logic            gin,
    output logic            gout,
    output logic            dinout,
    output logic            addsub,
    output logic            done,
    output logic [1:0]      step
);
    step_t step_q, step_d;
    logic [OP_W-1:0] op;
    logic [REG_SEL_W-1:0] x, y, rout_sel;
    logic rin_en, rout_en, arith;
    assign op    = ir[OP_LSB +: OP_W];
    assign x     = ir[X_LSB +: REG_SEL_W];
    assign y     = ir[Y_LSB +: REG_SEL_W];
    assign arith = op == OP_ADD || op == OP_SUB;
    assign step  = reset ? T0 : step_q;
    always_comb begin
        irin     = 1'b0;
        rin_en   = 1'b0;
        rout_en  = 1'b0;
        rout_sel = y;
        ain      = 1'b0;
        gin      = 1'b0;
        gout     = 1'b0;
        dinout   = 1'b0;
        addsub   = 1'b0;
        done     = 1'b0;
        if (!reset) begin
            case (step_q)
                T0: irin = run;
                T1: begin
                    rin_en   = op == OP_MV || op == OP_MVI;
                    rout_en  = op == OP_MV || arith;
                    rout_sel = arith ? x : y;
                    dinout   = op == OP_MVI;
                    ain      = arith;
                    done     = !arith;
                end
                T2: begin
                    rout_en = arith;
                    gin     = arith;
                    addsub  = op == OP_SUB;
                end
                T3: begin
                    gout   = arith;
                    rin_en = arith;
                    done   = 1'b1;
                end
                default: ;
            endcase
        end
        // done always wins so a finished instruction never advances past its last step
        step_d = done ? T0 : step_q == T0 ? (run ? T1 : T0) : step_t'(step_q + 2'd1);
    end
    always_ff @(posedge clock) step_q <= reset ? T0 : step_d;
    dec3to8 #(.W(REG_SEL_W)) u_rin  (.en_i(rin_en),  .sel_i(x),        .y_o(rin));
    dec3to8 #(.W(REG_SEL_W)) u_rout (.en_i(rout_en), .sel_i(rout_sel), .y_o(rout));
endmodule

// File: tb/tb_cpu_control.sv
// tb_cpu_control: directed per-scenario checks of the cpu_control step sequence and strobes.
module tb_cpu_control;
    logic clock = 1'b0, reset = 1'b1, run = 1'b1;
    logic [8:0] ir = 9'h1ff;
    logic irin, ain, gin, gout, dinout, addsub, done;
    logic [7:0] rin, rout;
    logic [1:0] step;
    int tests = 0, fails = 0;
    logic [24:0] obs;
    cpu_control dut (
        .clock(clock), .reset(reset), .run(run), .ir(ir), .irin(irin), .rin(rin), .rout(rout),
        .ain(ain), .gin(gin), .gout(gout), .dinout(dinout), .addsub(addsub), .done(done), .step(step)
    );
    always #5 clock = ~clock;
    assign obs = {irin, rin, rout, ain, gin, gout, dinout, addsub, done, step};
    function automatic logic [24:0] ev(input logic i, input logic [7:0] ri, input logic [7:0] ro,
                                       input logic a, input logic g, input logic go, input logic d,
                                       input logic s, input logic dn, input logic [1:0] st);
        return {i, ri, ro, a, g, go, d, s, dn, st};
    endfunction
    // bus drivers and register strobes must stay one-hot (or idle) in every cycle
    always @(negedge clock) begin
        #2;
        tests++;
        if ($countones({rout, gout, dinout}) > 1 || $countones(rin) > 1) begin
            fails++;
            $display("FAIL bus_onehot t=%0t rout=%b gout=%b dinout=%b rin=%b", $time, rout, gout, dinout, rin);
        end
    end
    task automatic test_reset();
        logic [24:0] e;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock); reset = 1'b1; run = 1'b1; ir = 9'b010_001_001; #1;
            tests++;
            if (obs !== 25'd0) begin fails++; $display("FAIL reset_hold c%0d got=%h exp=%h", i, obs, 25'd0); end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); reset = 1'b0; run = 1'b0; ir = 9'(i * 97 + 5); #1;
            e = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
            tests++;
            if (obs !== e) begin fails++; $display("FAIL idle_t0 c%0d got=%h exp=%h", i, obs, e); end
        end
    endtask
    task automatic run_seq(input string name, input int n, input logic [8:0] irs[8],
                           input logic runs[8], input logic [24:0] exps[8]);
        for (int i = 0; i < n; i++) begin
            @(negedge clock); run = runs[i]; ir = irs[i]; #1;
            tests++;
            if (obs !== exps[i]) begin fails++; $display("FAIL %s c%0d got=%h exp=%h", name, i, obs, exps[i]); end
        end
    endtask
    task automatic test_mvi();
        logic [8:0] irs[8] = '{default: 9'b001_010_000};
        logic runs[8] = '{1, 0, 0, 0, 0, 0, 0, 0};
        logic [24:0] e[8];
        e[0] = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
        e[1] = ev(0, 8'b0000_0100, 0, 0, 0, 0, 1, 0, 1, 2'd1);
        e[2] = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
        run_seq("mvi", 3, irs, runs, e);
    endtask
    task automatic test_mv();
        logic [8:0] irs[8] = '{9'b000_101_011, 9'b000_101_011, 9'b000_101_011, 9'b000_011_011,
                               9'b000_011_011, 9'b000_011_011, 9'd0, 9'd0};
        logic runs[8] = '{1, 0, 0, 1, 0, 0, 0, 0};
        logic [24:0] e[8];
        e[0] = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
        e[1] = ev(0, 8'b0010_0000, 8'b0000_1000, 0, 0, 0, 0, 0, 1, 2'd1);
        e[2] = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
        e[3] = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
        e[4] = ev(0, 8'b0000_1000, 8'b0000_1000, 0, 0, 0, 0, 0, 1, 2'd1);
        e[5] = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
        run_seq("mv", 6, irs, runs, e);
    endtask
    task automatic test_addsub(input logic sub);
        logic [8:0] irs[8] = '{default: {2'b01, sub, 6'b001_110}};
        logic runs[8] = '{1, 1, 0, 1, 0, 0, 0, 0};
        logic [24:0] e[8];
        e[0] = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
        e[1] = ev(0, 0, 8'b0000_0010, 1, 0, 0, 0, 0, 0, 2'd1);
        e[2] = ev(0, 0, 8'b0100_0000, 0, 1, 0, 0, sub, 0, 2'd2);
        e[3] = ev(0, 8'b0000_0010, 0, 0, 0, 1, 0, 0, 1, 2'd3);
        e[4] = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
        run_seq(sub ? "sub" : "add", 5, irs, runs, e);
    endtask
    task automatic test_back_to_back();
        logic [8:0] irs[8] = '{9'b001_011_000, 9'b001_011_000, 9'b010_100_101, 9'b010_100_101,
                               9'b010_100_101, 9'b010_100_101, 9'b111_000_000, 9'b111_000_000};
        logic runs[8] = '{default: 1};
        logic [24:0] e[8];
        e[0] = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
        e[1] = ev(0, 8'b0000_1000, 0, 0, 0, 0, 1, 0, 1, 2'd1);
        e[2] = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
        e[3] = ev(0, 0, 8'b0001_0000, 1, 0, 0, 0, 0, 0, 2'd1);
        e[4] = ev(0, 0, 8'b0010_0000, 0, 1, 0, 0, 0, 0, 2'd2);
        e[5] = ev(0, 8'b0001_0000, 0, 0, 0, 1, 0, 0, 1, 2'd3);
        e[6] = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
        e[7] = ev(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd1);
        run_seq("b2b", 8, irs, runs, e);
        @(negedge clock); run = 1'b0; #1;
        tests++;
        if (obs !== 25'd0) begin fails++; $display("FAIL b2b_end got=%h exp=%h", obs, 25'd0); end
    endtask
    task automatic test_reset_mid();
        logic [8:0] irs[8] = '{default: 9'b010_010_010};
        logic runs[8] = '{1, 0, 0, 0, 0, 0, 0, 0};
        logic [24:0] e[8];
        e[0] = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
        e[1] = ev(0, 0, 8'b0000_0100, 1, 0, 0, 0, 0, 0, 2'd1);
        e[2] = ev(0, 0, 8'b0000_0100, 0, 1, 0, 0, 0, 0, 2'd2);
        run_seq("add_r2r2", 3, irs, runs, e);
        reset = 1'b1; #1;
        tests++;
        if (obs !== 25'd0) begin fails++; $display("FAIL reset_in_t2 got=%h exp=%h", obs, 25'd0); end
        @(negedge clock); reset = 1'b0; #1;
        tests++;
        if (obs !== 25'd0) begin fails++; $display("FAIL after_reset got=%h exp=%h", obs, 25'd0); end
        @(negedge clock); #1;
        tests++;
        if (obs !== 25'd0) begin fails++; $display("FAIL after_reset2 got=%h exp=%h", obs, 25'd0); end
    endtask
    initial begin
        test_reset();
        test_mvi();
        test_mv();
        test_addsub(1'b1);
        test_addsub(1'b0);
        test_back_to_back();
        test_reset_mid();
        @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
